// File: rtl/tdm_demux41.sv
// Receive-side 4-channel TDM demultiplexer: recovers slot order from a frame-sync
// strobe, steers words into shadow registers and publishes all four channels per frame.
//
// state | meaning
// HUNT  | no frame alignment; waiting for a sync strobe to start slot 0
// LOCK  | aligned; slot counter tracks the transmitter, flywheels over missed syncs
module tdm_demux41 #(
    parameter int W          = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    input  logic         sync,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic         s1,
    output logic         s0,
    output logic         locked,
    output logic         frame_valid,
    output logic         sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [3:0]   miss_q, miss_d;
    logic [3:0]   miss_inc;
    logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [W-1:0] o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
    logic         fv_q, fv_d, se_q, se_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            miss_q  <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            o0_q    <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            o3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            miss_q  <= miss_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            o0_q    <= o0_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            o3_q    <= o3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        miss_d  = miss_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        o0_d    = o0_q;
        o1_d    = o1_q;
        o2_d    = o2_q;
        o3_d    = o3_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        sh0_d   = din;
                        slot_d  = 2'd1;
                        miss_d  = '0;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    // Any sync realigns; one away from slot 0 also abandons the partial frame.
                    if (sync) begin
                        se_d   = (slot_q != 2'd0);
                        sh0_d  = din;
                        slot_d = 2'd1;
                        miss_d = '0;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                se_d = 1'b1;
                                if (miss_inc == MISS_LIM) begin
                                    state_d = HUNT;
                                    slot_d  = 2'd0;
                                    miss_d  = '0;
                                end else begin
                                    miss_d = miss_inc;
                                    sh0_d  = din;
                                    slot_d = 2'd1;
                                end
                            end
                            2'd1: begin
                                sh1_d  = din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = din;
                                slot_d = 2'd3;
                            end
                            default: begin
                                o0_d   = sh0_q;
                                o1_d   = sh1_q;
                                o2_d   = sh2_q;
                                o3_d   = din;
                                fv_d   = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign o0          = o0_q;
    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign s1          = slot_q[1];
    assign s0          = slot_q[0];
    assign locked      = (state_q == LOCK);
    assign frame_valid = fv_q;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux41.sv
// Bench for tdm_demux41: directed frames against a slot-position model, checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_tdm_demux41;

    localparam int W  = 4;
    localparam int ML = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] o0, o1, o2, o3;
    logic         s1, s0, locked, frame_valid, sync_err;

    int errors = 0;
    int checks = 0;

    // model state
    logic         m_lk;
    int           m_pos;
    int           m_miss;
    logic [W-1:0] m_sh [4];
    logic [W-1:0] m_out [4];
    logic         m_fv, m_se;

    tdm_demux41 #(.W(W), .MISS_LIMIT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .s1(s1), .s0(s0),
        .locked(locked), .frame_valid(frame_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lk = 1'b0; m_pos = 0; m_miss = 0; m_fv = 1'b0; m_se = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = '0;
            m_out[i] = '0;
        end
    endtask

    // Frame-level rules: position 0..3 inside a frame; syncs mark position 0.
    task automatic model_step(input logic e, input logic sy, input logic [W-1:0] d);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (!e) return;
        if (!m_lk) begin
            if (sy) begin
                m_sh[0] = d; m_pos = 1; m_miss = 0; m_lk = 1'b1;
            end
        end else if (sy) begin
            m_se = (m_pos != 0);
            m_sh[0] = d; m_pos = 1; m_miss = 0;
        end else if (m_pos == 0) begin
            m_se = 1'b1;
            m_miss = m_miss + 1;
            if (m_miss == ML) begin
                m_lk = 1'b0; m_pos = 0; m_miss = 0;
            end else begin
                m_sh[0] = d; m_pos = 1;
            end
        end else if (m_pos == 3) begin
            for (int i = 0; i < 3; i++) m_out[i] = m_sh[i];
            m_out[3] = d;
            m_fv = 1'b1;
            m_pos = 0;
        end else begin
            m_sh[m_pos] = d;
            m_pos = m_pos + 1;
        end
    endtask

    always @(negedge clk) begin
        chk("o0", int'(o0), int'(m_out[0]));
        chk("o1", int'(o1), int'(m_out[1]));
        chk("o2", int'(o2), int'(m_out[2]));
        chk("o3", int'(o3), int'(m_out[3]));
        chk("slot", int'({s1, s0}), m_pos);
        chk("locked", int'(locked), int'(m_lk));
        chk("frame_valid", int'(frame_valid), int'(m_fv));
        chk("sync_err", int'(sync_err), int'(m_se));
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cyc(input logic e, input logic sy, input logic [W-1:0] d);
        en = e; sync = sy; din = d;
        @(posedge clk);
        model_step(e, sy, d);
        #1;
    endtask

    task automatic frame(input logic sy, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        cyc(1'b1, sy, a); cyc(1'b1, 1'b0, b); cyc(1'b1, 1'b0, c); cyc(1'b1, 1'b0, d);
    endtask

    task automatic outs_are(input string name, input logic [4*W-1:0] exp);
        chk(name, int'({o0, o1, o2, o3}), int'(exp));
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_outs", int'({o0, o1, o2, o3}), 0);
        chk("reset_locked", int'(locked), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // continuous frames
        cyc(1'b1, 1'b1, 4'hA);
        chk("lock_first_edge", int'(locked), 1);
        cyc(1'b1, 1'b0, 4'hB); cyc(1'b1, 1'b0, 4'hC); cyc(1'b1, 1'b0, 4'hD);
        chk("fv_abcd", int'(frame_valid), 1);
        outs_are("frame_abcd", 16'hABCD);
        frame(1'b1, 4'h5, 4'h6, 4'h7, 4'h8);
        outs_are("frame_5678", 16'h5678);

        // en toggling 1,0,1,0
        cyc(1'b1, 1'b1, 4'h9); cyc(1'b0, 1'b0, 4'h0);
        chk("slot_hold_gap", int'({s1, s0}), 1);
        cyc(1'b1, 1'b0, 4'hA); cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'hB); cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'hC);
        chk("fv_gapped", int'(frame_valid), 1);
        cyc(1'b0, 1'b0, 4'h0);
        outs_are("frame_gapped", 16'h9ABC);

        // misplaced sync at slot 2
        cyc(1'b1, 1'b1, 4'h1); cyc(1'b1, 1'b0, 4'h2); cyc(1'b1, 1'b1, 4'h3);
        chk("misplaced_err", int'(sync_err), 1);
        outs_are("misplaced_hold", 16'h9ABC);
        cyc(1'b1, 1'b0, 4'h4); cyc(1'b1, 1'b0, 4'h5); cyc(1'b1, 1'b0, 4'h6);
        outs_are("realigned_frame", 16'h3456);

        // two missed syncs
        frame(1'b0, 4'h7, 4'h8, 4'h9, 4'hA);
        outs_are("flywheel_frame", 16'h789A);
        cyc(1'b1, 1'b0, 4'hB);
        chk("second_miss_err", int'(sync_err), 1);
        chk("second_miss_unlock", int'(locked), 0);
        cyc(1'b1, 1'b0, 4'hC); cyc(1'b1, 1'b0, 4'hD); cyc(1'b1, 1'b0, 4'hE);
        frame(1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        outs_are("relock_frame", 16'h1234);

        // asynchronous reset at slot 2
        frame(1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
        cyc(1'b1, 1'b1, 4'h1); cyc(1'b1, 1'b0, 4'h2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        outs_are("async_reset_outs", 16'h0000);
        chk("async_reset_slot", int'({s1, s0}), 0);
        chk("async_reset_locked", int'(locked), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame(1'b0, 4'h5, 4'h6, 4'h7, 4'h8);
        outs_are("hunt_ignores", 16'h0000);
        frame(1'b1, 4'h5, 4'h6, 4'h7, 4'h8);
        outs_are("post_reset_frame", 16'h5678);

        // sync at slot 3
        cyc(1'b1, 1'b1, 4'h1); cyc(1'b1, 1'b0, 4'h2); cyc(1'b1, 1'b0, 4'h3);
        cyc(1'b1, 1'b1, 4'hE);
        chk("slot3_sync_err", int'(sync_err), 1);
        chk("slot3_no_fv", int'(frame_valid), 0);
        chk("slot3_slot", int'({s1, s0}), 1);
        cyc(1'b1, 1'b0, 4'hF); cyc(1'b1, 1'b0, 4'h0); cyc(1'b1, 1'b0, 4'h1);
        outs_are("slot3_shadow0", 16'hEF01);

        cyc(1'b0, 1'b0, 4'h0); cyc(1'b0, 1'b0, 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux41.md
# tdm_demux41

Receive-side 4-channel time-division demultiplexer: the other end of the 4:1 mux link. The transmitter selects one of four channels per slot with s1:s0. This block recovers the slot order from a frame-sync strobe and steers each incoming word to its channel register. It publishes all four channels together once per frame. It sits directly after the serial link input and feeds channel consumers in parallel.

## Interface
Parameters:
- W, 1, data width per slot (width of din and of each channel output)
- MISS_LIMIT, 2, number of consecutive missing sync strobes at expected slot 0 before lock is dropped (range 1..15)

Ports:
- clk  input  1  single clock for the block; all logic on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous release is the integrator's responsibility
- en  input  1  sample strobe; din and sync are valid only in cycles with en=1
- din  input  W  slot data from the link
- sync  input  1  frame marker; high in the en cycle that carries the channel 0 (i0) slot
- o0, o1, o2, o3  output  W each  recovered channel words, held between frames
- s1, s0  output  1 each  slot index expected for the next en cycle (s1 is the MSB)
- locked  output  1  high while in LOCK
- frame_valid  output  1  one-cycle pulse when o0..o3 have just been updated
- sync_err  output  1  one-cycle pulse on a misplaced sync or a missed sync

## Operation
- Reset (rst_n=0, asynchronous) puts the block in this state: state=HUNT, slot=0, miss counter=0, shadow registers=0, o0..o3=0, locked=0, frame_valid=0, sync_err=0, {s1,s0}=0.
- Cycles with en=0 change nothing except that frame_valid and sync_err clear. The slot counter does not advance.
- HUNT state:
  - en=1 with sync=0: discard the sample.
  - en=1 with sync=1: capture din into shadow0, set slot=1, clear the miss counter, go to LOCK.
- LOCK state, en=1, sync at the expected place:
  - slot 1 or 2: capture din into shadow1 or shadow2, then slot+1.
  - slot 3 and the frame is clean: load o0..o2 from shadow0..2 and o3 from din on the same edge, pulse frame_valid, set slot=0.
  - slot 0 with sync=1: capture din into shadow0, set slot=1, clear the miss counter.
- LOCK state, en=1, slot 0 with sync=0 (missed sync):
  - Pulse sync_err and increment the miss counter.
  - If the new count equals MISS_LIMIT: go to HUNT, slot=0, miss counter=0; o0..o3 hold.
  - Otherwise (flywheel): treat the sample as channel 0, capture into shadow0, set slot=1. The frame is published normally but counted as a miss.
- LOCK state, en=1, sync=1 at slot 1, 2 or 3 (misplaced sync):
  - Pulse sync_err and abandon the partial frame; o0..o3 hold and there is no frame_valid.
  - Realign: capture din into shadow0, set slot=1, clear the miss counter, stay in LOCK.
- Simultaneous events: at slot 3 with sync=1, the misplaced-sync rule wins. No frame is published.
- {s1,s0} always equals the internal slot counter. locked equals (state==LOCK).
- Data path is pure steering with no arithmetic. The slot counter is 2 bits and wraps 3 -> 0. The miss counter is 4 bits and saturates at MISS_LIMIT.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: o3 and frame_valid update on the clk edge that samples the slot-3 en cycle. o0 lags its sample by 3 en-cycles plus 0 clk.
- frame_valid and sync_err are high for exactly one clk.
- The minimum frame is 4 consecutive en cycles, which gives a frame every 4 clk at full rate. Gaps of any length between en cycles are legal.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first en=1 cycle after release is handled from HUNT.

## Test plan
- W=4, MISS_LIMIT=2, continuous en. Send sync with slots A,B,C,D, then 5,6,7,8. Required: locked=1 after the first edge; frame_valid pulses with o0..o3=A,B,C,D, then 5,6,7,8, four clk apart; sync_err never pulses.
- Same frame as above with en toggling 1,0,1,0. Required: identical outputs; frame_valid every 8 clk; {s1,s0} holds during en=0 cycles.
- After lock, put sync at slot 2. Required: sync_err pulses, there is no frame_valid for the partial frame, and o0..o3 keep their old values. The next frame sent from the new sync publishes correctly.
- After lock, drop sync for 2 consecutive frames. Required: the first miss gives a sync_err pulse while the frame is still published. The second miss gives sync_err, locked falls to 0 and {s1,s0}=0. Data is ignored until the next sync.
- Assert rst_n=0 at slot 2 with o0..o3=A,B,C,D. Required: all outputs read 0 before the next clk edge, locked=0, and no frame_valid until a fresh sync-aligned 4-slot frame completes.
- At slot 3, assert sync=1 with din=E. Required: sync_err pulses, there is no frame_valid, shadow0=E and {s1,s0}=1.
